// File: rtl/instruction_fetch_if.sv
// Fetch-unit bus bundle: instruction memory port, redirect input, decode handshake and fault flag.
interface instruction_fetch_if #(
    parameter int INSTRUCTION_SIZE = 32,
    parameter int ADDRESS_SIZE     = 32
);
    logic [ADDRESS_SIZE-1:0]     imem_address;
    logic [INSTRUCTION_SIZE-1:0] imem_instruction;
    logic                        fetch_enable;
    logic                        redirect_valid;
    logic [ADDRESS_SIZE-1:0]     redirect_target;
    logic                        out_valid;
    logic                        out_ready;
    logic [INSTRUCTION_SIZE-1:0] out_instruction;
    logic [ADDRESS_SIZE-1:0]     out_pc;
    logic                        fetch_fault;

    modport master (
        output imem_address,
        input  imem_instruction,
        input  fetch_enable,
        input  redirect_valid,
        input  redirect_target,
        output out_valid,
        input  out_ready,
        output out_instruction,
        output out_pc,
        output fetch_fault
    );

    modport slave (
        input  imem_address,
        output imem_instruction,
        output fetch_enable,
        output redirect_valid,
        output redirect_target,
        input  out_valid,
        output out_ready,
        input  out_instruction,
        input  out_pc,
        input  fetch_fault
    );
endinterface

// File: rtl/instruction_fetch.sv
// Instruction fetch: pc register, combinational imem read, circular fetch queue toward decode.
// FETCH_MISALIGN_TRAP_EN: misaligned redirects enter FAULT instead of being force-aligned.
module instruction_fetch #(
    parameter int                    INSTRUCTION_SIZE = 32,
    parameter int                    ADDRESS_SIZE     = 32,
    parameter logic [ADDRESS_SIZE-1:0] RESET_ADDRESS  = '0,
    parameter int                    QUEUE_DEPTH      = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    instruction_fetch_if.master  bus
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(QUEUE_DEPTH);

    typedef struct packed {
        logic [ADDRESS_SIZE-1:0]     pc;
        logic [INSTRUCTION_SIZE-1:0] instr;
    } entry_t;

    typedef enum logic [1:0] {FETCH, IDLE, FAULT} state_t;

    state_t                  state, state_nxt;
    logic [ADDRESS_SIZE-1:0] pc, pc_nxt;
    logic [ADDRESS_SIZE-1:0] redirect_pc;
    entry_t [QUEUE_DEPTH-1:0] queue;
    entry_t                  head;
    logic [PTR_W-1:0]        rd_ptr, wr_ptr;
    logic [PTR_W:0]          count;
    logic                    full, push, pop, flush;

    assign full = (count == DEPTH_C);
    assign head = queue[rd_ptr];

`ifdef FETCH_MISALIGN_TRAP_EN
    logic misaligned;
    assign misaligned  = |bus.redirect_target[1:0];
    assign redirect_pc = bus.redirect_target;
`else
    // Low bits are dropped so the pc always stays word aligned.
    assign redirect_pc = bus.redirect_target & ~ADDRESS_SIZE'(3);
`endif

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        push      = 1'b0;
        pop       = 1'b0;
        flush     = 1'b0;
        if (bus.redirect_valid) begin
            // Redirect wins over everything: drop queue contents including a same-cycle pop.
            flush     = 1'b1;
            pc_nxt    = redirect_pc;
            state_nxt = bus.fetch_enable ? FETCH : IDLE;
`ifdef FETCH_MISALIGN_TRAP_EN
            if (misaligned) state_nxt = FAULT;
`endif
        end else begin
            pop  = (count != '0) && bus.out_ready;
            push = (state == FETCH) && (!full || pop);
            if (push) pc_nxt = pc + ADDRESS_SIZE'(4);
            if (state != FAULT) state_nxt = bus.fetch_enable ? FETCH : IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= FETCH;
            pc     <= RESET_ADDRESS;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (flush) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) wr_ptr <= wr_ptr + PTR_W'(1);
                if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
                count <= count + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
            end
        end
    end

    // Entry storage needs no reset: the outputs are gated by out_valid.
    always_ff @(posedge clk) begin
        if (push) queue[wr_ptr] <= '{pc: pc, instr: bus.imem_instruction};
    end

    assign bus.imem_address    = pc;
    assign bus.out_valid       = (count != '0);
    assign bus.out_pc          = bus.out_valid ? head.pc : '0;
    assign bus.out_instruction = bus.out_valid ? head.instr : '0;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign bus.fetch_fault = (state == FAULT);
`else
    assign bus.fetch_fault = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, corner sequences, random run against a queue model.
module tb_instruction_fetch;

    localparam int DEPTH = 2;

    logic clk;
    logic rst_n;
    int   compared   = 0;
    int   mismatched = 0;

    instruction_fetch_if #(.INSTRUCTION_SIZE(32), .ADDRESS_SIZE(32)) bus ();

    instruction_fetch #(
        .INSTRUCTION_SIZE(32),
        .ADDRESS_SIZE    (32),
        .RESET_ADDRESS   (32'h0),
        .QUEUE_DEPTH     (DEPTH)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memw(input logic [5:0] w);
        case (w)
            6'd0:    return 32'hFFFFFFFF;
            6'd1:    return 32'h00100093;
            6'd2:    return 32'h00200113;
            6'd4:    return 32'h20700193;
            default: return 32'h10000000 + 32'(w);
        endcase
    endfunction

    assign bus.imem_instruction = memw(bus.imem_address[7:2]);

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        rst_n, fe, rdy, rv;
        logic [31:0] tgt;
        logic        e_v;
        logic [31:0] e_pc, e_ins, e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic fe, input logic rdy, input logic rv,
                                input logic [31:0] tgt, input logic ev, input logic [31:0] epc,
                                input logic [31:0] eins, input logic [31:0] eaddr);
        vec_t v;
        v.rst_n = r; v.fe = fe; v.rdy = rdy; v.rv = rv; v.tgt = tgt;
        v.e_v = ev; v.e_pc = epc; v.e_ins = eins; v.e_addr = eaddr;
        return v;
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
    } ent_t;

    vec_t tbl[$];
    ent_t mq[$];
    logic [31:0] mpc;
    logic        men, mfault;

    task automatic check_outputs(input string tag, input logic ev, input logic [31:0] epc,
                                 input logic [31:0] eins, input logic [31:0] eaddr,
                                 input logic efault);
        chk({tag, ".valid"}, 32'(bus.out_valid), 32'(ev));
        chk({tag, ".pc"},    bus.out_pc, epc);
        chk({tag, ".instr"}, bus.out_instruction, eins);
        chk({tag, ".addr"},  bus.imem_address, eaddr);
        chk({tag, ".fault"}, 32'(bus.fetch_fault), 32'(efault));
    endtask

    initial begin
        rst_n = 1'b0;
        bus.fetch_enable    = 1'b1;
        bus.out_ready       = 1'b1;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;

        // rst, fe, rdy, rv, tgt | valid, out_pc, instr, imem_address (checked before the row's inputs apply)
        tbl.push_back(mk(1,1,1,0,0,     0,0,0,0));
        tbl.push_back(mk(1,1,1,0,0,     1,0,memw(0),32'h4));
        tbl.push_back(mk(1,1,1,0,0,     1,32'h4,memw(1),32'h8));
        tbl.push_back(mk(0,1,1,0,0,     1,32'h8,memw(2),32'hc));
        tbl.push_back(mk(1,1,0,0,0,     0,0,0,0));
        tbl.push_back(mk(1,1,0,0,0,     1,0,memw(0),32'h4));
        tbl.push_back(mk(1,1,0,0,0,     1,0,memw(0),32'h8));
        tbl.push_back(mk(1,1,0,0,0,     1,0,memw(0),32'h8));
        tbl.push_back(mk(1,1,0,0,0,     1,0,memw(0),32'h8));
        tbl.push_back(mk(1,1,1,0,0,     1,0,memw(0),32'h8));
        tbl.push_back(mk(1,1,1,0,0,     1,32'h4,memw(1),32'hc));
        tbl.push_back(mk(1,1,0,0,0,     1,32'h8,memw(2),32'h10));
        tbl.push_back(mk(1,1,0,1,32'h10,1,32'h8,memw(2),32'h10));
        tbl.push_back(mk(1,1,1,0,0,     0,0,0,32'h10));
        tbl.push_back(mk(1,0,0,0,0,     1,32'h10,32'h20700193,32'h14));
        tbl.push_back(mk(1,0,1,0,0,     1,32'h10,memw(4),32'h18));
        tbl.push_back(mk(1,0,1,0,0,     1,32'h14,memw(5),32'h18));
        tbl.push_back(mk(1,0,1,0,0,     0,0,0,32'h18));
        tbl.push_back(mk(1,1,1,0,0,     0,0,0,32'h18));
        tbl.push_back(mk(1,1,1,0,0,     0,0,0,32'h18));
        tbl.push_back(mk(1,1,1,0,0,     1,32'h18,memw(6),32'h1c));

        repeat (2) @(posedge clk);
        @(negedge clk);
        foreach (tbl[i]) begin
            check_outputs($sformatf("row%0d", i), tbl[i].e_v, tbl[i].e_pc, tbl[i].e_ins,
                          tbl[i].e_addr, 1'b0);
            rst_n               = tbl[i].rst_n;
            bus.fetch_enable    = tbl[i].fe;
            bus.out_ready       = tbl[i].rdy;
            bus.redirect_valid  = tbl[i].rv;
            bus.redirect_target = tbl[i].tgt;
            @(negedge clk);
        end

        // pc wraps from the top word to address 0
        bus.out_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_target = 32'hFFFFFFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check_outputs("wrap0", 1'b0, 32'h0, 32'h0, 32'hFFFFFFFC, 1'b0);
        @(negedge clk);
        check_outputs("wrap1", 1'b1, 32'hFFFFFFFC, memw(6'd63), 32'h0, 1'b0);

        // misaligned redirect
        bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_target = 32'h12;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
        check_outputs("fault0", 1'b0, 32'h0, 32'h0, 32'h12, 1'b1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_outputs($sformatf("fault_hold%0d", k), 1'b0, 32'h0, 32'h0, 32'h12, 1'b1);
        end
        bus.redirect_valid = 1'b1; bus.redirect_target = 32'h14;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        check_outputs("fault_exit", 1'b0, 32'h0, 32'h0, 32'h14, 1'b0);
        @(negedge clk);
        check_outputs("fault_resume", 1'b1, 32'h14, memw(5), 32'h18, 1'b0);
`else
        check_outputs("misalign0", 1'b0, 32'h0, 32'h0, 32'h10, 1'b0);
        @(negedge clk);
        check_outputs("misalign1", 1'b1, 32'h10, memw(4), 32'h14, 1'b0);
`endif

        // asynchronous reset mid-stream
        @(negedge clk);
        chk("pre_reset.valid", 32'(bus.out_valid), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset.valid", 32'(bus.out_valid), 32'd0);
        chk("async_reset.addr", bus.imem_address, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_outputs("post_reset", 1'b1, 32'h0, memw(0), 32'h4, 1'b0);

        // randomized run against the queue model
        rst_n = 1'b0;
        @(negedge clk);
        rst_n  = 1'b1;
        mq.delete();
        mpc    = 32'h0;
        men    = 1'b1;
        mfault = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            logic        fe, rdy, rv, p_pop, p_push;
            logic [31:0] tgt;
            check_outputs($sformatf("rnd%0d", c), mq.size() > 0,
                          mq.size() > 0 ? mq[0].pc : 32'h0,
                          mq.size() > 0 ? mq[0].ins : 32'h0, mpc, mfault);
            fe  = ($urandom_range(0, 7) != 0);
            rdy = $urandom_range(0, 1) == 1;
            rv  = ($urandom_range(0, 11) == 0);
            tgt = $urandom() & ~32'd3;
            if ($urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            bus.fetch_enable    = fe;
            bus.out_ready       = rdy;
            bus.redirect_valid  = rv;
            bus.redirect_target = tgt;
            if (rv) begin
                mq.delete();
`ifdef FETCH_MISALIGN_TRAP_EN
                mpc = tgt;
                if (tgt[1:0] != 2'b00) mfault = 1'b1;
                else begin mfault = 1'b0; men = fe; end
`else
                mpc = tgt & ~32'd3;
                men = fe;
`endif
            end else begin
                p_pop  = (mq.size() > 0) && rdy;
                p_push = !mfault && men && (mq.size() < DEPTH || p_pop);
                if (p_pop) void'(mq.pop_front());
                if (p_push) begin
                    mq.push_back('{pc: mpc, ins: memw(mpc[7:2])});
                    mpc = mpc + 32'd4;
                end
                men = fe;
            end
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter INSTRUCTION_SIZE, default 32: instruction word width.
REQ-002 SHALL have parameter ADDRESS_SIZE, default 32: byte-address width.
REQ-003 SHALL have parameter RESET_ADDRESS, default 0: first fetch address after reset.
REQ-004 SHALL have parameter QUEUE_DEPTH, default 2: fetch queue entries, power of two, at least 2.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-007 SHALL have port imem_address, output, ADDRESS_SIZE bits: byte address to the instruction memory (word = address[ADDRESS_SIZE-1:2]).
REQ-008 SHALL have port imem_instruction, input, INSTRUCTION_SIZE bits: combinational memory read data, valid in the same cycle as imem_address.
REQ-009 SHALL have port fetch_enable, input, 1 bit: permits new fetches.
REQ-010 SHALL have port redirect_valid, input, 1 bit: branch/jump redirect request.
REQ-011 SHALL have port redirect_target, input, ADDRESS_SIZE bits: redirect byte address.
REQ-012 SHALL have port out_valid, output, 1 bit: queue head valid.
REQ-013 SHALL have port out_ready, input, 1 bit: decode accepts head.
REQ-014 SHALL have port out_instruction, output, INSTRUCTION_SIZE bits: head instruction.
REQ-015 SHALL have port out_pc, output, ADDRESS_SIZE bits: head instruction address.
REQ-016 SHALL have port fetch_fault, output, 1 bit: misaligned-redirect fault flag.

Function
REQ-017 SHALL hold pc register; imem_address SHALL equal pc every cycle.
REQ-018 SHALL have FSM states FETCH, IDLE, FAULT. FETCH when fetch_enable=1, IDLE when fetch_enable=0, FAULT per REQ-029.
REQ-019 SHALL push {pc, imem_instruction} and set pc <= pc+4 on an edge when state=FETCH, redirect_valid=0 and (queue not full or pop in same cycle).
REQ-020 SHALL pop head on an edge with out_valid=1 and out_ready=1. Full queue with simultaneous pop SHALL push and pop together, count unchanged.
REQ-021 SHALL drive out_valid=1 iff queue count>0. out_instruction/out_pc SHALL be the head entry and stay stable while out_valid=1 and out_ready=0.
REQ-022 SHALL leave pc unchanged and push nothing while full without pop, or while IDLE. The queue still drains in IDLE.
REQ-023 SHALL, on an edge with redirect_valid=1, flush all queue entries (including any head pop in that cycle), push nothing, and load pc <= redirect_target. Redirect SHALL override push, pop and fetch_enable.
REQ-024 SHALL give a minimum latency of one edge from a redirect/reset-release to out_valid=1 with the target's instruction.
REQ-025 SHALL wrap pc modulo 2^ADDRESS_SIZE (max word address + 4 -> 0) with no flag.

Reset
REQ-026 SHALL, on rst_n=0, immediately set pc=RESET_ADDRESS, queue count=0, state=FETCH, out_valid=0, fetch_fault=0.
REQ-027 SHALL reset out_instruction and out_pc to 0.
REQ-028 SHALL, on reset mid-operation, discard queued entries and restart fetching at RESET_ADDRESS on the first edge after release.

Configuration
REQ-029 SHALL, with FETCH_MISALIGN_TRAP_EN defined, treat a redirect with target[1:0]!=0 as follows: flush, set pc <= target, enter FAULT, set fetch_fault=1. FAULT fetches nothing; only an aligned redirect (-> FETCH/IDLE, fault cleared) or reset exits it.
REQ-030 SHALL, without FETCH_MISALIGN_TRAP_EN, load pc with target[1:0] forced to 00, never enter FAULT, and tie fetch_fault to 0.

Verification
REQ-031 SHALL cover: memory words 0..2 = FFFFFFFF, 00100093, 00200113, out_ready=1 after reset -> out_pc 0,4,8 on consecutive cycles with matching instructions.
REQ-032 SHALL cover: out_ready=0 for 5 cycles -> 2 entries held (pc 0,4), imem_address stays 8, head stable; then out_ready=1 -> pc 8 delivered third.
REQ-033 SHALL cover: redirect_valid=1, target=0x10 while queue full -> next cycle out_valid=0 and pc=0x10; following cycle out_pc=0x10, instruction 20700193.
REQ-034 SHALL cover: fetch_enable=0 with 2 entries queued -> both drain, out_valid=0, pc constant; re-enable -> fetch resumes at held pc.
REQ-035 SHALL cover: redirect target=0x12 -> with macro, fetch_fault=1, out_valid=0 until redirect 0x14; without macro, next out_pc=0x10.
REQ-036 SHALL cover: rst_n pulled low mid-stream -> out_valid=0 asynchronously; after release, first out_pc=RESET_ADDRESS.
